// File: rtl/wb_march_pkg.sv
// Shared definitions for the Wishbone March-test initiator.
// Holds the controller state enum, the 2-bit March element encoding and
// the per-element behaviour tables, indexed by element number:
//   bit n of each table describes element Mn.
package wb_march_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_CHECK,
        ST_NEXT,
        ST_FINISH
    } march_state_e;

    typedef enum logic [1:0] {
        EL_M0 = 2'd0,
        EL_M1 = 2'd1,
        EL_M2 = 2'd2,
        EL_M3 = 2'd3
    } march_elem_e;

    // M2 and M3 walk the window from the top word down
    localparam logic [3:0] ELEM_DESC   = 4'b1100;
    // every element except M0 starts each word with a read
    localparam logic [3:0] ELEM_HAS_RD = 4'b1110;
    // M2 expects the inverted background
    localparam logic [3:0] ELEM_RD_INV = 4'b0100;
    // M0..M2 write each word; M3 only reads
    localparam logic [3:0] ELEM_HAS_WR = 4'b0111;
    // M1 writes the inverted background
    localparam logic [3:0] ELEM_WR_INV = 4'b0010;

    localparam logic [3:0] SEL_ALL = 4'hF;

endpackage

// File: rtl/wb_march_master_if.sv
// Wishbone classic bus bundle between the March initiator and the SRAM
// test-chip slave.
//   wbm_cyc_o / wbm_stb_o / wbm_we_o : cycle, strobe, write enable
//   wbm_sel_o                        : byte selects
//   wbm_adr_o / wbm_dat_o            : byte address, write data
//   wbm_dat_i / wbm_ack_i            : read data, acknowledge
interface wb_march_master_if;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i
    );

endinterface

// File: rtl/wb_master_xfer.sv
// Single Wishbone classic transfer engine with ack timeout.
// The caller holds req_i (with we_i/adr_i/wdata_i stable) for as long as the
// transfer is outstanding and drops it the cycle after done_o.
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   req_i              : transfer requested this cycle (drives cyc/stb)
//   we_i, adr_i, wdata_i : direction, byte address, write data
//   done_o             : ack received or wait budget exhausted (1 cycle)
//   rdata_o            : read data captured on the acking cycle
//   timed_out_o        : qualifies done_o; no ack within TIMEOUT cycles
//   wbm                : Wishbone master port
module wb_master_xfer
    import wb_march_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] wdata_i,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        timed_out_o,
    wb_march_master_if.master wbm
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_q, wait_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          ack_seen;
    logic          expire;

    // bus outputs are all gated by req_i so the idle bus is all-zero
    assign wbm.wbm_cyc_o = req_i;
    assign wbm.wbm_stb_o = req_i;
    assign wbm.wbm_we_o  = req_i & we_i;
    assign wbm.wbm_sel_o = req_i ? SEL_ALL : 4'h0;
    assign wbm.wbm_adr_o = req_i ? adr_i : 32'h0;
    assign wbm.wbm_dat_o = (req_i & we_i) ? wdata_i : 32'h0;

    // an ack while idle belongs to nobody and is dropped here
    assign ack_seen = req_i & wbm.wbm_ack_i;
    // this is the TIMEOUT-th strobed cycle without ack; an ack arriving in
    // the same cycle still wins
    assign expire   = req_i & ~wbm.wbm_ack_i & (wait_q == CW'(TIMEOUT - 1));

    assign done_o      = ack_seen | expire;
    assign timed_out_o = expire;
    assign rdata_o     = rdata_q;

    always_comb begin
        wait_d  = '0;
        rdata_d = rdata_q;
        if (req_i && !wbm.wbm_ack_i) begin
            wait_d = wait_q + 1'b1;
        end
        if (ack_seen && !we_i) begin
            rdata_d = wbm.wbm_dat_i;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wait_q  <= '0;
            rdata_q <= '0;
        end else begin
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: rtl/wb_march_master.sv
// Self-contained 4-element March test initiator for one SRAM window.
//   state  | meaning
//   IDLE   | waiting for start; result outputs hold the last run
//   REQ    | one Wishbone transfer outstanding (cyc=stb=1)
//   CHECK  | compare captured read data against the expected background
//   NEXT   | step idx / element, bus idle for this cycle
//   FINISH | done raised, busy dropped; returns to IDLE
// Ports:
//   wb_clk_i, wb_rst_i     : clock, synchronous active-high reset
//   start, pattern         : launch pulse and background pattern
//   busy, done, pass, timeout, fail_addr, fail_data : status / result
//   wbm                    : Wishbone master port
module wb_march_master
    import wb_march_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          NUM_WORDS = 256,
    parameter int          TIMEOUT   = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start,
    input  logic [31:0] pattern,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [31:0] fail_addr,
    output logic [31:0] fail_data,
    wb_march_master_if.master wbm
);

    localparam int             IW       = $clog2(NUM_WORDS);
    localparam logic [IW-1:0]  IDX_LAST = IW'(NUM_WORDS - 1);

    march_state_e  state_q, state_d;
    march_elem_e   elem_q, elem_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          op_we_q, op_we_d;
    logic [31:0]   pat_q, pat_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic          timeout_q, timeout_d;
    logic [31:0]   fail_addr_q, fail_addr_d;
    logic [31:0]   fail_data_q, fail_data_d;

    logic          xfer_done;
    logic          xfer_to;
    logic [31:0]   xfer_rdata;
    logic [31:0]   cur_adr;
    logic [31:0]   exp_data;
    logic [31:0]   wr_data;
    logic          idx_end;
    march_elem_e   elem_nxt;

    assign cur_adr  = BASE_ADDR + (32'(idx_q) << 2);
    assign exp_data = ELEM_RD_INV[elem_q] ? ~pat_q : pat_q;
    assign wr_data  = ELEM_WR_INV[elem_q] ? ~pat_q : pat_q;
    assign idx_end  = ELEM_DESC[elem_q] ? (idx_q == '0) : (idx_q == IDX_LAST);
    assign elem_nxt = march_elem_e'(elem_q + 2'd1);

    wb_master_xfer #(
        .TIMEOUT (TIMEOUT)
    ) u_xfer (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .req_i       (state_q == ST_REQ),
        .we_i        (op_we_q),
        .adr_i       (cur_adr),
        .wdata_i     (wr_data),
        .done_o      (xfer_done),
        .rdata_o     (xfer_rdata),
        .timed_out_o (xfer_to),
        .wbm         (wbm)
    );

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        idx_d       = idx_q;
        op_we_d     = op_we_q;
        pat_d       = pat_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pat_d       = pattern;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    timeout_d   = 1'b0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                    elem_d      = EL_M0;
                    idx_d       = '0;
                    op_we_d     = ~ELEM_HAS_RD[EL_M0];
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                if (xfer_done) begin
                    if (xfer_to) begin
                        timeout_d   = 1'b1;
                        fail_addr_d = cur_adr;
                        fail_data_d = '0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        state_d     = ST_FINISH;
                    end else if (op_we_q) begin
                        state_d = ST_NEXT;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (xfer_rdata != exp_data) begin
                    fail_addr_d = cur_adr;
                    fail_data_d = xfer_rdata;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    state_d     = ST_FINISH;
                end else if (ELEM_HAS_WR[elem_q]) begin
                    // trailing write goes to the same word
                    op_we_d = 1'b1;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (!idx_end) begin
                    idx_d   = ELEM_DESC[elem_q] ? (idx_q - 1'b1) : (idx_q + 1'b1);
                    op_we_d = ~ELEM_HAS_RD[elem_q];
                    state_d = ST_REQ;
                end else if (elem_q == EL_M3) begin
                    pass_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    elem_d  = elem_nxt;
                    idx_d   = ELEM_DESC[elem_nxt] ? IDX_LAST : '0;
                    op_we_d = ~ELEM_HAS_RD[elem_nxt];
                    state_d = ST_REQ;
                end
            end
            ST_FINISH: begin
                // start is deliberately not looked at here
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            elem_q      <= EL_M0;
            idx_q       <= '0;
            op_we_q     <= 1'b0;
            pat_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            idx_q       <= idx_d;
            op_we_q     <= op_we_d;
            pat_q       <= pat_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign timeout   = timeout_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;

endmodule
